obi_dp_ram: RTL and testbench

OBI_DP_RAM -- requirements
Module: obi_dp_ram

---
 rtl/obi_dp_ram.sv | 99 +++++++++
 tb/tb_obi_dp_ram.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/obi_dp_ram.sv
// Multi-port OBI RAM: every port is always granted outside reset, writes land at the
// accepting edge, and each accept returns exactly one response RD_LATENCY cycles later.

module obi_dp_ram_resp_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  acc_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [RD_LATENCY-1:0]                 vld_q;
    logic [RD_LATENCY-1:0][DATA_WIDTH-1:0] dat_q;

    // Data stages carry zero whenever their valid bit is clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q[0] <= acc_i;
            dat_q[0] <= acc_i ? data_i : '0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign rvalid_o = vld_q[RD_LATENCY-1];
    assign rdata_o  = vld_q[RD_LATENCY-1] ? dat_q[RD_LATENCY-1] : '0;
endmodule

module obi_dp_ram #(
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int NUM_PORTS  = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NUM_PORTS-1:0]                  req_i,
    output logic [NUM_PORTS-1:0]                  gnt_o,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  addr_i,
    input  logic [NUM_PORTS-1:0]                  we_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] be_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  wdata_i,
    output logic [NUM_PORTS-1:0]                  rvalid_o,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  rdata_o
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFS  = $clog2(BYTES);
    localparam int IDX_W = ADDR_WIDTH - OFFS;
    localparam int WORDS = 2 ** IDX_W;

    // Left uninitialised on purpose; testbenches preload it hierarchically.
    logic [DATA_WIDTH-1:0] mem_q [WORDS];

    logic [NUM_PORTS-1:0]                 acc;
    logic [NUM_PORTS-1:0][IDX_W-1:0]      idx;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rd_word;
    logic [NUM_PORTS-1:0][OFFS-1:0]       unused_lo;

    assign gnt_o = rst_i ? '0 : req_i;
    assign acc   = req_i & gnt_o;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign idx[p]       = addr_i[p][ADDR_WIDTH-1:OFFS];
        assign unused_lo[p] = addr_i[p][OFFS-1:0];
        // Sampled at the accepting edge, so reads see pre-write contents.
        assign rd_word[p]   = we_i[p] ? '0 : mem_q[idx[p]];

        obi_dp_ram_resp_pipe #(
            .DATA_WIDTH (DATA_WIDTH),
            .RD_LATENCY (RD_LATENCY)
        ) u_pipe (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .acc_i    (acc[p]),
            .data_i   (rd_word[p]),
            .rvalid_o (rvalid_o[p]),
            .rdata_o  (rdata_o[p])
        );
    end

    // Ascending port order: the last NBA to a byte wins, i.e. the highest port.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int b = 0; b < BYTES; b++) begin
                if (acc[p] && we_i[p] && be_i[p][b]) begin
                    mem_q[idx[p]][b*8 +: 8] <= wdata_i[p][b*8 +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_obi_dp_ram.sv
// Drives three RAMs (latency 1, 2, 3) with identical traffic and checks every
// response against a reference memory via a timestamped scoreboard.

module tb_obi_dp_ram;
    localparam int NI = 3;

    typedef struct {
        int          inst;
        int          port;
        int          exp_cyc;
        logic [31:0] data;
    } sb_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           req;
    logic [1:0][11:0]     addr;
    logic [1:0]           we;
    logic [1:0][3:0]      be;
    logic [1:0][31:0]     wdata;
    logic [NI-1:0][1:0]       gnt;
    logic [NI-1:0][1:0]       rv;
    logic [NI-1:0][1:0][31:0] rd;

    sb_t         sbq[$];
    logic [31:0] mdl [int];
    int          cyc = 0;
    int          nchk = 0;
    int          nerr = 0;
    bit          chk_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        obi_dp_ram #(
            .ADDR_WIDTH (12),
            .DATA_WIDTH (32),
            .RD_LATENCY (g + 1),
            .NUM_PORTS  (2)
        ) u_dut (
            .clk_i    (clk),
            .rst_i    (rst),
            .req_i    (req),
            .gnt_o    (gnt[g]),
            .addr_i   (addr),
            .we_i     (we),
            .be_i     (be),
            .wdata_i  (wdata),
            .rvalid_o (rv[g]),
            .rdata_o  (rd[g])
        );
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                for (int p = 0; p < 2; p++) begin
                    logic exp_g;
                    int   k;
                    int   late;
                    exp_g = rst ? 1'b0 : req[p];
                    nchk++;
                    assert (gnt[i][p] === exp_g) else begin
                        nerr++;
                        $error("FAIL gnt inst%0d p%0d cyc%0d got %b exp %b", i, p, cyc, gnt[i][p], exp_g);
                    end
                    if (rv[i][p] === 1'b1) begin
                        k = -1;
                        for (int j = 0; j < sbq.size(); j++)
                            if (k < 0 && sbq[j].inst == i && sbq[j].port == p) k = j;
                        nchk++;
                        assert (k >= 0) else begin
                            nerr++;
                            $error("FAIL spurious_rvalid inst%0d p%0d cyc%0d got 1 exp 0", i, p, cyc);
                        end
                        if (k >= 0) begin
                            nchk++;
                            assert (cyc === sbq[k].exp_cyc) else begin
                                nerr++;
                                $error("FAIL latency inst%0d p%0d got cyc%0d exp cyc%0d", i, p, cyc, sbq[k].exp_cyc);
                            end
                            nchk++;
                            assert (rd[i][p] === sbq[k].data) else begin
                                nerr++;
                                $error("FAIL rdata inst%0d p%0d cyc%0d got %h exp %h", i, p, cyc, rd[i][p], sbq[k].data);
                            end
                            sbq.delete(k);
                        end
                    end else begin
                        nchk++;
                        assert (rv[i][p] === 1'b0 && rd[i][p] === 32'h0) else begin
                            nerr++;
                            $error("FAIL idle_out inst%0d p%0d cyc%0d got rv=%b rd=%h exp rv=0 rd=0", i, p, cyc, rv[i][p], rd[i][p]);
                        end
                    end
                    late = 0;
                    for (int j = sbq.size() - 1; j >= 0; j--) begin
                        if (sbq[j].inst == i && sbq[j].port == p && sbq[j].exp_cyc <= cyc) begin
                            late++;
                            sbq.delete(j);
                        end
                    end
                    nchk++;
                    assert (late === 0) else begin
                        nerr++;
                        $error("FAIL missing_rvalid inst%0d p%0d cyc%0d got %0d lost exp 0", i, p, cyc, late);
                    end
                end
            end
        end
    end

    task automatic step(input logic [1:0] rq, input logic [1:0] w,
                        input logic [11:0] a0, input logic [11:0] a1,
                        input logic [3:0] b0, input logic [3:0] b1,
                        input logic [31:0] d0, input logic [31:0] d1);
        rst = 1'b0;
        req = rq;  we = w;
        addr[0] = a0; addr[1] = a1;
        be[0] = b0;   be[1] = b1;
        wdata[0] = d0; wdata[1] = d1;
        for (int p = 0; p < 2; p++) begin
            if (rq[p]) begin
                logic [31:0] e;
                e = w[p] ? 32'h0 : mdl[int'(addr[p] >> 2)];
                for (int i = 0; i < NI; i++) sbq.push_back('{i, p, cyc + i + 1, e});
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (rq[p] && w[p]) begin
                logic [31:0] cur;
                int          ix;
                ix  = int'(addr[p] >> 2);
                cur = mdl.exists(ix) ? mdl[ix] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (be[p][b]) cur[b*8 +: 8] = wdata[p][b*8 +: 8];
                mdl[ix] = cur;
            end
        end
        @(posedge clk); #1;
        req = 2'b00; we = 2'b00;
    endtask

    task automatic wr(input int p, input logic [11:0] a, input logic [31:0] d, input logic [3:0] b);
        if (p == 0) step(2'b01, 2'b01, a, 12'h0, b, 4'h0, d, 32'h0);
        else        step(2'b10, 2'b10, 12'h0, a, 4'h0, b, 32'h0, d);
    endtask

    task automatic rdq(input int p, input logic [11:0] a);
        if (p == 0) step(2'b01, 2'b00, a, 12'h0, 4'h0, 4'h0, 32'h0, 32'h0);
        else        step(2'b10, 2'b00, 12'h0, a, 4'h0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Responses due after the reset edge are dropped; a write is held on port 0
    // throughout and must not reach memory.
    task automatic pulse_reset(input int n);
        rst = 1'b1;
        req = 2'b01; we = 2'b01; addr[0] = 12'h010; be[0] = 4'hF; wdata[0] = 32'hBAD0BAD0;
        for (int j = sbq.size() - 1; j >= 0; j--)
            if (sbq[j].exp_cyc > cyc) sbq.delete(j);
        idle(n);
        rst = 1'b0; req = 2'b00; we = 2'b00;
    endtask

    initial begin
        rst = 1'b1; req = '0; we = '0; addr = '0; be = '0; wdata = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(1);

        wr(0, 12'h010, 32'hDEADBEEF, 4'hF);
        rdq(0, 12'h010);
        idle(3);

        wr(0, 12'h020, 32'h11223344, 4'hF);
        wr(0, 12'h022, 32'hAABBCCDD, 4'h5);
        rdq(0, 12'h020);
        idle(3);

        step(2'b11, 2'b11, 12'h030, 12'h030, 4'hF, 4'h3, 32'h01010101, 32'h02020202);
        rdq(1, 12'h030);
        idle(3);

        wr(0, 12'h040, 32'h0, 4'hF);
        step(2'b11, 2'b10, 12'h040, 12'h040, 4'h0, 4'hF, 32'h0, 32'h00000055);
        step(2'b11, 2'b00, 12'h040, 12'h041, 4'h0, 4'h0, 32'h0, 32'h0);
        idle(3);

        rdq(1, 12'h010);
        rdq(1, 12'h020);
        rdq(1, 12'h030);
        rdq(1, 12'h040);
        rdq(1, 12'h010);
        idle(4);

        wr(0, 12'h050, 32'hCAFEF00D, 4'hF);
        rdq(1, 12'h050);
        step(2'b11, 2'b01, 12'h060, 12'h050, 4'hC, 4'h0, 32'h12345678, 32'h0);
        rdq(0, 12'h060);
        idle(4);

        rdq(0, 12'h010);
        rdq(0, 12'h020);
        pulse_reset(1);
        idle(4);
        rdq(0, 12'h010);
        rdq(1, 12'h020);
        idle(5);

        nchk++;
        assert (sbq.size() === 0) else begin
            nerr++;
            $error("FAIL drain got %0d pending exp 0", sbq.size());
        end
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
